fd_pipe: RTL and testbench

FD_PIPE -- requirements
Module: fd_pipe

---
 rtl/fd_pkg.sv | 22 ++
 rtl/fd_stage.sv | 34 +++
 rtl/fd_pipe.sv | 105 ++++++++++
 tb/tb_fd_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared constants and helpers for the fd_pipe register pipeline and its stage cells.
package fd_pkg;

   localparam string GSR_ENABLED  = "ENABLED";
   localparam string GSR_DISABLED = "DISABLED";
   localparam int    FD_MAX_DEPTH = 32'sd16;
   localparam int    FD_MAX_WIDTH = 32'sd64;

   // Ceiling log2 with a floor of 1, so single-entry selects still get a 1-bit port.
   function automatic int fd_clog2(input int n);
      int r;
      int v;
      r = 32'sd0;
      v = n - 32'sd1;
      while (v > 32'sd0) begin
         r = r + 32'sd1;
         v = v / 32'sd2;
      end
      return (r < 32'sd1) ? 32'sd1 : r;
   endfunction

endpackage

// File: rtl/fd_stage.sv
// One pipeline cell: data plus valid flag in a single register, with clock enable,
// synchronous LSR load and an asynchronous global-init force.
module fd_stage
   import fd_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
   input  logic             i_clk,
   input  logic             i_init_n,
   input  logic             i_lsr,
   input  logic             i_ce,
   input  logic [WIDTH:0]   i_d,
   output logic [WIDTH:0]   o_q
);

   logic [WIDTH:0] r_q;

   // Bit 0 is the valid flag; both reset paths load INIT with the flag cleared.
   always_ff @(posedge i_clk or negedge i_init_n) begin
      if (!i_init_n) begin
         r_q <= {INIT, 1'b0};
      end else if (i_lsr) begin
         r_q <= {INIT, 1'b0};
      end else if (i_ce) begin
         r_q <= i_d;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fd_pipe.sv
// Fixed-depth data/valid delay line with a selectable tap and an occupancy counter.
// GSRN/PURN are the global init nets; integrations without them tie both high.
module fd_pipe
   import fd_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}},
   parameter string            GSR   = GSR_ENABLED
) (
   input  logic                                   CK,
   input  logic                                   LSR,
   input  logic                                   CE,
   input  logic [WIDTH-1:0]                       D,
   input  logic                                   DV,
   input  logic [fd_clog2(DEPTH)-1:0]             TAPSEL,
   input  logic                                   GSRN,
   input  logic                                   PURN,
   output logic [WIDTH-1:0]                       Q,
   output logic                                   QV,
   output logic [WIDTH-1:0]                       QT,
   output logic                                   QTV,
   output logic [fd_clog2(DEPTH + 32'sd1)-1:0]    CNT
);

   localparam int            CW      = fd_clog2(DEPTH + 32'sd1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam bit            USE_GSR = (GSR == GSR_ENABLED);

   if ((WIDTH < 32'sd1) || (WIDTH > FD_MAX_WIDTH) || (DEPTH < 32'sd1) || (DEPTH > FD_MAX_DEPTH) ||
       ((GSR != GSR_ENABLED) && (GSR != GSR_DISABLED))) begin : g_bad_params
      $error("fd_pipe: parameter out of range");
   end

   logic           w_init_n;
   logic [WIDTH:0] w_stage [DEPTH];
   logic [WIDTH:0] w_tap;
   logic           w_last_v;
   logic [CW-1:0]  w_cnt_next;
   logic [CW-1:0]  r_cnt;

   assign w_init_n = PURN & (USE_GSR ? GSRN : 1'b1);

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH:0] w_d;
      if (g == 32'sd0) begin : g_head
         assign w_d = {D, DV};
      end else begin : g_body
         assign w_d = w_stage[g - 32'sd1];
      end
      fd_stage #(
         .WIDTH (WIDTH),
         .INIT  (INIT)
      ) u_stage (
         .i_clk    (CK),
         .i_init_n (w_init_n),
         .i_lsr    (LSR),
         .i_ce     (CE),
         .i_d      (w_d),
         .o_q      (w_stage[g])
      );
   end

   // Tap select; any TAPSEL past the end falls back to the last stage.
   always_comb begin
      w_tap = w_stage[DEPTH - 32'sd1];
      for (int i = 0; i < DEPTH; i++) begin
         w_tap = (int'(TAPSEL) == i) ? w_stage[i] : w_tap;
      end
   end

   assign w_last_v = w_stage[DEPTH - 32'sd1][0];

   // Occupancy delta: a valid entering and one leaving on the same edge cancel.
   always_comb begin
      w_cnt_next = r_cnt;
      if (DV && !w_last_v) begin
         w_cnt_next = r_cnt + CNT_ONE;
      end else if (!DV && w_last_v) begin
         w_cnt_next = r_cnt - CNT_ONE;
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   // Occupancy counter shares the stage reset and enable behaviour.
   always_ff @(posedge CK or negedge w_init_n) begin
      if (!w_init_n) begin
         r_cnt <= {CW{1'b0}};
      end else if (LSR) begin
         r_cnt <= {CW{1'b0}};
      end else if (CE) begin
         r_cnt <= w_cnt_next;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign Q   = w_stage[DEPTH - 32'sd1][WIDTH:1];
   assign QV  = w_last_v;
   assign QT  = w_tap[WIDTH:1];
   assign QTV = w_tap[0];
   assign CNT = r_cnt;

endmodule

// File: tb/tb_fd_pipe.sv
// Self-checking bench for fd_pipe: four configurations driven in parallel against
// a stage-array reference model whose occupancy is recounted from the valid flags.
module tb_fd_pipe;

   localparam int NI = 4;

   logic       ck = 1'b0;
   logic       lsr, ce, dv, gsrn, purn;
   logic [7:0] d;
   logic [2:0] tapsel;

   logic [7:0] q   [NI];
   logic       qv  [NI];
   logic [7:0] qt  [NI];
   logic       qtv [NI];
   logic [2:0] c0, c1, c2;
   logic [0:0] c3;
   logic [3:0] cntx [NI];

   int n_checks = 0;
   int n_errors = 0;

   int         dep    [NI];
   bit         gsr_en [NI];
   logic [7:0] init_v [NI];
   logic [7:0] md     [NI][16];
   logic       mv     [NI][16];

   always #5 ck = ~ck;

   fd_pipe #(.WIDTH(8), .DEPTH(4)) u_dut0 (
      .CK(ck), .LSR(lsr), .CE(ce), .D(d), .DV(dv), .TAPSEL(tapsel[1:0]), .GSRN(gsrn), .PURN(purn),
      .Q(q[0]), .QV(qv[0]), .QT(qt[0]), .QTV(qtv[0]), .CNT(c0));
   fd_pipe #(.WIDTH(8), .DEPTH(5), .INIT(8'hA5)) u_dut1 (
      .CK(ck), .LSR(lsr), .CE(ce), .D(d), .DV(dv), .TAPSEL(tapsel), .GSRN(gsrn), .PURN(purn),
      .Q(q[1]), .QV(qv[1]), .QT(qt[1]), .QTV(qtv[1]), .CNT(c1));
   fd_pipe #(.WIDTH(8), .DEPTH(4), .GSR("DISABLED")) u_dut2 (
      .CK(ck), .LSR(lsr), .CE(ce), .D(d), .DV(dv), .TAPSEL(tapsel[1:0]), .GSRN(gsrn), .PURN(purn),
      .Q(q[2]), .QV(qv[2]), .QT(qt[2]), .QTV(qtv[2]), .CNT(c2));
   fd_pipe #(.WIDTH(8), .DEPTH(1)) u_dut3 (
      .CK(ck), .LSR(lsr), .CE(ce), .D(d), .DV(dv), .TAPSEL(tapsel[0:0]), .GSRN(gsrn), .PURN(purn),
      .Q(q[3]), .QV(qv[3]), .QT(qt[3]), .QTV(qtv[3]), .CNT(c3));

   always_comb begin
      cntx[0] = {1'b0, c0};
      cntx[1] = {1'b0, c1};
      cntx[2] = {1'b0, c2};
      cntx[3] = {3'b000, c3};
   end

   function automatic bit init_act(int k);
      return (!purn) || (gsr_en[k] && !gsrn);
   endfunction

   task automatic model_clear(int k);
      for (int i = 0; i < 16; i++) begin
         md[k][i] = init_v[k];
         mv[k][i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         if (init_act(k) || lsr) model_clear(k);
         else if (ce) begin
            for (int i = dep[k] - 1; i > 0; i--) begin
               md[k][i] = md[k][i-1];
               mv[k][i] = mv[k][i-1];
            end
            md[k][0] = d;
            mv[k][0] = dv;
         end
      end
   endtask

   task automatic model_async();
      for (int k = 0; k < NI; k++) if (init_act(k)) model_clear(k);
   endtask

   function automatic int tap_idx(int k);
      int t;
      t = (k == 1) ? int'(tapsel) : (k == 3) ? int'(tapsel[0]) : int'(tapsel[1:0]);
      return (t >= dep[k]) ? dep[k] - 1 : t;
   endfunction

   function automatic logic [21:0] exp_vec(int k);
      int cnt;
      int ti;
      cnt = 0;
      for (int i = 0; i < dep[k]; i++) cnt += int'(mv[k][i]);
      ti = tap_idx(k);
      return {md[k][dep[k]-1], mv[k][dep[k]-1], md[k][ti], mv[k][ti], 4'(cnt)};
   endfunction

   function automatic logic [21:0] obs_vec(int k);
      return {q[k], qv[k], qt[k], qtv[k], cntx[k]};
   endfunction

   task automatic step();
      @(posedge ck);
      model_edge();
      #1;
   endtask

   task automatic pulse_reset();
      lsr = 1'b1;
      step();
      lsr = 1'b0;
   endtask

   task automatic test_reset();
      lsr = 1'b1; ce = 1'b0; dv = 1'b1; d = 8'h3C; tapsel = 3'd0;
      step();
      lsr = 1'b0;
      n_checks++;
      if (q[0] !== 8'hFF || qv[0] !== 1'b0 || c0 !== 3'd0) begin
         n_errors++;
         $display("FAIL reset_outputs got q=%h qv=%b cnt=%0d exp q=ff qv=0 cnt=0", q[0], qv[0], c0);
      end
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (obs_vec(k) !== exp_vec(k)) begin
            n_errors++;
            $display("FAIL reset_model inst%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
         end
      end
   endtask

   task automatic test_latency();
      logic [7:0] vals [5];
      logic [2:0] ecnt [5];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      ecnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      ce = 1'b1; dv = 1'b1;
      for (int e = 0; e < 5; e++) begin
         d = vals[e];
         step();
         n_checks++;
         if (c0 !== ecnt[e]) begin
            n_errors++;
            $display("FAIL latency_cnt edge%0d got %0d exp %0d", e + 1, c0, ecnt[e]);
         end
         if (e == 3) begin
            n_checks++;
            if (q[0] !== 8'h11 || qv[0] !== 1'b1) begin
               n_errors++;
               $display("FAIL latency_q4 got q=%h qv=%b exp q=11 qv=1", q[0], qv[0]);
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_errors++;
               $display("FAIL latency_model inst%0d edge%0d got %h exp %h", k, e + 1, obs_vec(k), exp_vec(k));
            end
         end
      end
      ce = 1'b0; dv = 1'b0;
   endtask

   task automatic test_stall();
      pulse_reset();
      ce = 1'b1; dv = 1'b1; tapsel = 3'd1;
      d = 8'h11; step();
      d = 8'h22; step();
      ce = 1'b0;
      for (int s = 0; s < 3; s++) begin
         d = 8'($urandom); dv = 1'($urandom);
         step();
         n_checks++;
         if (q[0] !== 8'hFF || qv[0] !== 1'b0 || c0 !== 3'd2 || qt[0] !== 8'h11) begin
            n_errors++;
            $display("FAIL stall_hold cyc%0d got q=%h qv=%b cnt=%0d qt=%h exp q=ff qv=0 cnt=2 qt=11",
                     s, q[0], qv[0], c0, qt[0]);
         end
      end
      ce = 1'b1; dv = 1'b1;
      d = 8'h33; step();
      n_checks++;
      if (qv[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_early got qv=%b exp 0", qv[0]);
      end
      d = 8'h44; step();
      n_checks++;
      if (q[0] !== 8'h11 || qv[0] !== 1'b1 || c0 !== 3'd4) begin
         n_errors++;
         $display("FAIL stall_latency got q=%h qv=%b cnt=%0d exp q=11 qv=1 cnt=4", q[0], qv[0], c0);
      end
      ce = 1'b0; dv = 1'b0;
   endtask

   task automatic test_tap();
      logic [7:0] vals [4];
      logic [7:0] etap [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      etap = '{8'h44, 8'h33, 8'h22, 8'h11};
      pulse_reset();
      ce = 1'b1; dv = 1'b1;
      for (int e = 0; e < 4; e++) begin d = vals[e]; step(); end
      ce = 1'b0;
      for (int t = 0; t < 4; t++) begin
         tapsel = 3'(t);
         #1;
         n_checks++;
         if (qt[0] !== etap[t] || qtv[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL tap_sweep sel%0d got qt=%h qtv=%b exp qt=%h qtv=1", t, qt[0], qtv[0], etap[t]);
         end
      end
      ce = 1'b1; d = 8'h55; step();
      ce = 1'b0; tapsel = 3'd7;
      #1;
      n_checks++;
      if (qt[1] !== 8'h11 || qtv[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL tap_clamp got qt=%h qtv=%b exp qt=11 qtv=1", qt[1], qtv[1]);
      end
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (obs_vec(k) !== exp_vec(k)) begin
            n_errors++;
            $display("FAIL tap_model inst%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
         end
      end
      dv = 1'b0;
   endtask

   task automatic test_bubble_reset();
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      pulse_reset();
      ce = 1'b1;
      for (int e = 0; e < 4; e++) begin
         d = 8'($urandom); dv = pat[e];
         step();
      end
      n_checks++;
      if (c0 !== 3'd2) begin
         n_errors++;
         $display("FAIL bubble_cnt got %0d exp 2", c0);
      end
      lsr = 1'b1; ce = 1'b0; dv = 1'b1;
      step();
      lsr = 1'b0;
      n_checks++;
      if (c0 !== 3'd0 || qv[0] !== 1'b0 || q[0] !== 8'hFF) begin
         n_errors++;
         $display("FAIL bubble_lsr got cnt=%0d qv=%b q=%h exp cnt=0 qv=0 q=ff", c0, qv[0], q[0]);
      end
      for (int t = 0; t < 4; t++) begin
         tapsel = 3'(t);
         #1;
         n_checks++;
         if (qtv[0] !== 1'b0 || qt[0] !== 8'hFF) begin
            n_errors++;
            $display("FAIL bubble_valids sel%0d got qtv=%b qt=%h exp qtv=0 qt=ff", t, qtv[0], qt[0]);
         end
      end
      dv = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         ce     = ($urandom_range(3) != 0);
         dv     = 1'($urandom);
         d      = 8'($urandom);
         lsr    = ($urandom_range(31) == 0);
         tapsel = 3'($urandom);
         step();
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_errors++;
               $display("FAIL random_model inst%0d cyc%0d got %h exp %h", k, n, obs_vec(k), exp_vec(k));
            end
         end
      end
      lsr = 1'b0;
   endtask

   task automatic test_global_init();
      pulse_reset();
      ce = 1'b1; dv = 1'b1; tapsel = 3'd2;
      for (int e = 0; e < 6; e++) begin d = 8'($urandom); step(); end
      gsrn = 1'b0;
      #1;
      model_async();
      n_checks++;
      if (q[0] !== 8'hFF || c0 !== 3'd0 || qv[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL gsr_clear got q=%h qv=%b cnt=%0d exp q=ff qv=0 cnt=0", q[0], qv[0], c0);
      end
      n_checks++;
      if (qv[2] !== 1'b1 || c2 !== 3'd4) begin
         n_errors++;
         $display("FAIL gsr_ignored got qv=%b cnt=%0d exp qv=1 cnt=4", qv[2], c2);
      end
      for (int s = 0; s < 2; s++) begin
         if (s == 1) gsrn = 1'b1;
         d = 8'($urandom);
         step();
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
               n_errors++;
               $display("FAIL gsr_model inst%0d step%0d got %h exp %h", k, s, obs_vec(k), exp_vec(k));
            end
         end
      end
      gsrn = 1'b1;
      purn = 1'b0;
      #1;
      model_async();
      n_checks++;
      if (q[2] !== 8'hFF || c2 !== 3'd0 || qv[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL pur_clear got q=%h qv=%b cnt=%0d exp q=ff qv=0 cnt=0", q[2], qv[2], c2);
      end
      purn = 1'b1;
      d = 8'h5A;
      step();
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (obs_vec(k) !== exp_vec(k)) begin
            n_errors++;
            $display("FAIL pur_model inst%0d got %h exp %h", k, obs_vec(k), exp_vec(k));
         end
      end
      ce = 1'b0; dv = 1'b0;
   endtask

   initial begin
      dep[0] = 4; dep[1] = 5; dep[2] = 4; dep[3] = 1;
      gsr_en[0] = 1'b1; gsr_en[1] = 1'b1; gsr_en[2] = 1'b0; gsr_en[3] = 1'b1;
      init_v[0] = 8'hFF; init_v[1] = 8'hA5; init_v[2] = 8'hFF; init_v[3] = 8'hFF;
      for (int k = 0; k < NI; k++) model_clear(k);
      gsrn = 1'b1; purn = 1'b1; lsr = 1'b0; ce = 1'b0; dv = 1'b0; d = 8'h00; tapsel = 3'd0;
      test_reset();
      test_latency();
      test_stall();
      test_tap();
      test_bubble_reset();
      test_random();
      test_global_init();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
